// File: rtl/buf_write_arbiter_if.sv
// Bus between the producers and the write arbiter, plus its path to the
// circular buffer's parallel write port.
//
// Handshake: a producer holds req[i] high while beat i is presented on its
// req_data slice. The beat is consumed in the cycle where ack[i] is high.
// ack and buf_w_en rise together, and both are combinational, so
// the buffer samples buf_par_in on the same rising edge that the producer
// sees ack and advances its data.
interface buf_write_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int K     = 4
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]         req;
    logic [N*WIDTH*K-1:0] req_data;
    logic [N-1:0]         gnt;
    logic [N-1:0]         ack;
    logic                 buf_ready;
    logic                 buf_full;
    logic                 buf_w_en;
    logic [WIDTH*K-1:0]   buf_par_in;
    logic                 busy;
    logic                 dbg_state;   // 0 = IDLE, 1 = BURST
    logic [SEL_W-1:0]     dbg_last;    // round-robin pointer

    // Producer/buffer side of the bus
    modport master (
        output req, req_data, buf_ready, buf_full,
        input  gnt, ack, buf_w_en, buf_par_in, busy, dbg_state, dbg_last
    );

    // Arbiter side of the bus
    modport slave (
        input  req, req_data, buf_ready, buf_full,
        output gnt, ack, buf_w_en, buf_par_in, busy, dbg_state, dbg_last
    );
endinterface

// File: rtl/buf_write_arbiter.sv
// Round-robin write arbiter. It shares the buffer's K-word parallel write
// port among N producers. A grant lasts for up to MAX_BURST beats, so each
// producer's words stay contiguous in the buffer. A grant is revoked after
// STALL_MAX consecutive stalled cycles. One IDLE cycle always separates
// two grants.
module buf_write_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int K         = 4,
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    buf_write_arbiter_if.slave bus
);
    localparam int DW      = WIDTH * K;
    localparam int SEL_W   = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W  = $clog2(MAX_BURST) + 1;
    localparam int STALL_W = $clog2(STALL_MAX) + 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [SEL_W-1:0]   pick;
    logic               found;
    logic               sel_req;
    logic               beat;
    int                 idx;

    // Round-robin search that starts one past the last grantee
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_q) + i) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    // Write datapath. A full buffer blocks the write even when buf_ready is high.
    always_comb begin
        sel_req        = bus.req[sel_q];
        beat           = (state_q == BURST) && sel_req && bus.buf_ready && !bus.buf_full;
        bus.buf_w_en   = beat;
        bus.ack        = beat ? (N'(1) << sel_q) : '0;
        bus.buf_par_in = (state_q == BURST) ? bus.req_data[int'(sel_q)*DW +: DW] : '0;
    end

    // Next-state logic: choose a grantee in IDLE, then count beats and stalls in BURST
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    gnt_d   = N'(1) << pick;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!sel_req) begin
                    state_d = IDLE;
                end else if (beat) begin
                    beat_d  = beat_q + 1'b1;
                    stall_d = '0;
                    if (beat_q == BEAT_W'(MAX_BURST - 1)) state_d = IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_q == STALL_W'(STALL_MAX - 1)) state_d = IDLE;
                end
                // When a grant ends, advance the pointer past the grantee.
                // The pointer also advances when the grant is revoked.
                if (state_d == IDLE) begin
                    gnt_d   = '0;
                    last_d  = sel_q;
                    beat_d  = '0;
                    stall_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers. Reset ends any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
            gnt_q   <= '0;
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.dbg_state = state_q;
    assign bus.dbg_last  = last_q;
endmodule

// File: tb/tb_buf_write_arbiter.sv
// Bench for buf_write_arbiter. It drives two instances in parallel:
// a: MAX_BURST=4, STALL_MAX=8
// b: MAX_BURST=1, STALL_MAX=3
// Each instance is compared every cycle against a transaction-level model
// that tracks the owner, the beats done, the stalls seen and the rotating
// pointer.
module tb_buf_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int K  = 4;
    localparam int DW = W * K;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            buf_ready, buf_full;

    buf_write_arbiter_if #(.N(N), .WIDTH(W), .K(K)) ifa ();
    buf_write_arbiter_if #(.N(N), .WIDTH(W), .K(K)) ifb ();

    assign ifa.req = req;  assign ifa.req_data = req_data;
    assign ifa.buf_ready = buf_ready;  assign ifa.buf_full = buf_full;
    assign ifb.req = req;  assign ifb.req_data = req_data;
    assign ifb.buf_ready = buf_ready;  assign ifb.buf_full = buf_full;

    buf_write_arbiter #(.N(N), .WIDTH(W), .K(K), .MAX_BURST(4), .STALL_MAX(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    buf_write_arbiter #(.N(N), .WIDTH(W), .K(K), .MAX_BURST(1), .STALL_MAX(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [DW-1:0] exp_q[$];

    int own [2];               // current owner, -1 when none
    int nb  [2];               // beats done in this grant
    int ns  [2];               // consecutive stalls
    int ptr [2];               // last grantee
    int mb  [2] = '{4, 1};
    int sm  [2] = '{8, 3};

    int acks_a [N];
    int acks_b;
    int gord[$];
    logic [N-1:0]  prev_gb;
    logic [N-1:0]  smp_gnt_a;
    logic          smp_wen_a, smp_busy_a;
    logic [DW-1:0] smp_par_a;
    logic [1:0]    smp_last_a;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_out(input int d, output logic [N-1:0] g, output logic [N-1:0] a,
                                      output logic w, output logic [DW-1:0] p, output logic b);
        g = '0; a = '0; w = 1'b0; p = '0; b = 1'b0;
        if (own[d] >= 0) begin
            g[own[d]] = 1'b1;
            b = 1'b1;
            p = req_data[own[d]*DW +: DW];
            if (req[own[d]] && buf_ready && !buf_full) begin
                w = 1'b1;
                a[own[d]] = 1'b1;
            end
        end
    endfunction

    function automatic void model_step(input int d);
        logic wr;
        if (rst) begin
            own[d] = -1; nb[d] = 0; ns[d] = 0; ptr[d] = N - 1;
        end else if (own[d] < 0) begin
            for (int k = 1; k <= N; k++)
                if (own[d] < 0 && req[(ptr[d] + k) % N]) begin
                    own[d] = (ptr[d] + k) % N; nb[d] = 0; ns[d] = 0;
                end
        end else begin
            wr = req[own[d]] && buf_ready && !buf_full;
            if (!req[own[d]]) begin
                ptr[d] = own[d]; own[d] = -1;
            end else if (wr) begin
                nb[d]++; ns[d] = 0;
                if (nb[d] == mb[d]) begin ptr[d] = own[d]; own[d] = -1; end
            end else begin
                ns[d]++;
                if (ns[d] == sm[d]) begin ptr[d] = own[d]; own[d] = -1; end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Runs one clock: checks the outputs at the falling edge, then advances
    // the model at the rising edge.
    task automatic step();
        logic [N-1:0] eg, ea, ag, aa;
        logic ew, eb, aw, ab;
        logic [DW-1:0] ep, ap;
        string pre;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_out(d, eg, ea, ew, ep, eb);
            if (d == 0) begin
                ag = ifa.gnt; aa = ifa.ack; aw = ifa.buf_w_en; ap = ifa.buf_par_in; ab = ifa.busy;
            end else begin
                ag = ifb.gnt; aa = ifb.ack; aw = ifb.buf_w_en; ap = ifb.buf_par_in; ab = ifb.busy;
            end
            pre = (d == 0) ? "a" : "b";
            chk({pre, "_gnt"}, 64'(ag), 64'(eg));
            chk({pre, "_ack"}, 64'(aa), 64'(ea));
            chk({pre, "_w_en"}, 64'(aw), 64'(ew));
            chk({pre, "_par_in"}, 64'(ap), 64'(ep));
            chk({pre, "_busy"}, 64'(ab), 64'(eb));
            if (d == 0 && ew) exp_q.push_back(ep);
        end
        if (ifa.buf_w_en) begin
            if (exp_q.size() == 0) chk("a_sb_underflow", 64'd1, 64'd0);
            else chk("a_sb_data", 64'(ifa.buf_par_in), 64'(exp_q.pop_front()));
        end
        for (int i = 0; i < N; i++) if (ifa.ack[i]) acks_a[i]++;
        if (ifb.ack != '0) acks_b++;
        if (ifb.gnt != '0 && prev_gb == '0)
            for (int i = 0; i < N; i++) if (ifb.gnt[i]) gord.push_back(i);
        prev_gb    = ifb.gnt;
        smp_gnt_a  = ifa.gnt;  smp_wen_a = ifa.buf_w_en;  smp_busy_a = ifa.busy;
        smp_par_a  = ifa.buf_par_in;  smp_last_a = ifa.dbg_last;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; buf_ready = 1'b1; buf_full = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) acks_a[i] = 0;
        acks_b = 0;
        gord.delete();
    endtask

    // ---------------- test sequence ----------------
    int cyc, g0cnt;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        own = '{-1, -1}; nb = '{0, 0}; ns = '{0, 0}; ptr = '{N - 1, N - 1};
        prev_gb = '0;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        chk("rst_gnt", 64'(smp_gnt_a), 64'd0);
        chk("rst_busy", 64'(smp_busy_a), 64'd0);
        chk("rst_last", 64'(smp_last_a), 64'd3);

        // Single producer 2 holding req for 6 beats
        req_data[2*DW +: DW] = 32'h0A0F190C;
        req = 4'b0100;
        cyc = 0;
        for (int c = 0; c < 40 && acks_a[2] < 6; c++) begin
            step();
            cyc++;
            if (cyc == 2) chk("t1_gnt", 64'(smp_gnt_a), 64'b0100);
            if (cyc == 2) chk("t1_par", 64'(smp_par_a), 64'h0A0F190C);
        end
        chk("t1_cycles", 64'(cyc), 64'd8);
        chk("t1_acks", 64'(acks_a[2]), 64'd6);
        req = '0;
        step();

        // Round robin on the MAX_BURST=1 instance
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 10; c++) step();
        chk("rr_grants", 64'(gord.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", 64'(i < gord.size() ? gord[i] : -1), 64'(exp_order[i]));
        chk("rr_acks", 64'(acks_b), 64'd5);

        // Back-pressure on producer 1
        do_reset();
        req = 4'b0010;
        cyc = 0;
        for (int c = 0; c < 30 && acks_a[1] < 4; c++) begin
            buf_ready = !(c >= 1 && c <= 3);
            step();
            cyc++;
            if (c >= 1 && c <= 3) chk("bp_stall_wen", 64'(smp_wen_a), 64'd0);
        end
        chk("bp_acks", 64'(acks_a[1]), 64'd4);
        chk("bp_cycles", 64'(cyc), 64'd8);
        req = '0; buf_ready = 1'b1;
        step();

        // Stall revoke with the buffer full
        do_reset();
        buf_full = 1'b1;
        req = 4'b0011;
        g0cnt = 0;
        for (int c = 0; c < 11; c++) begin
            step();
            if (smp_gnt_a == 4'b0001) g0cnt++;
        end
        chk("sr_g0_cycles", 64'(g0cnt), 64'd8);
        chk("sr_acks0", 64'(acks_a[0]), 64'd0);
        chk("sr_next_gnt", 64'(smp_gnt_a), 64'b0010);
        buf_full = 1'b0; req = '0;
        step(); step();

        // Early release by producer 3
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 20 && acks_a[3] < 2; c++) step();
        req = '0;
        step();
        step();
        chk("er_acks", 64'(acks_a[3]), 64'd2);
        chk("er_gnt", 64'(smp_gnt_a), 64'd0);
        chk("er_last", 64'(smp_last_a), 64'd3);
        req = 4'b1001;
        step(); step();
        chk("er_next_gnt", 64'(smp_gnt_a), 64'b0001);
        req = '0;
        for (int c = 0; c < 6; c++) step();

        // Reset during a burst of producer 2
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20 && acks_a[2] < 2; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = '0;
        step();
        chk("mr_gnt", 64'(smp_gnt_a), 64'd0);
        chk("mr_wen", 64'(smp_wen_a), 64'd0);
        chk("mr_busy", 64'(smp_busy_a), 64'd0);
        chk("mr_last", 64'(smp_last_a), 64'd3);
        req = 4'b1111;
        step(); step();
        chk("mr_next_gnt", 64'(smp_gnt_a), 64'b0001);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom_range(0, 15));
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            buf_ready = ($urandom_range(0, 9) < 8);
            buf_full  = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; req = '0;
        step(); step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
